// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for an eight-digit hex seven-segment display.
// Values are double-buffered so that a new value replaces the old one only at a frame boundary.
module seven_seg_scanner #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   active_q, active_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic          tick;
  logic          wrap;

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (sel_q == 3'd7);

  // load is a bare strobe with no backpressure: it is accepted in every cycle outside reset.
  // When it coincides with wrap it bypasses the shadow so the new frame starts with it at once.
  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    sel_d        = tick ? sel_q + 3'd1 : sel_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = wrap;
    if (load) begin
      shadow_d = value;
      if (wrap) begin
        active_d  = value;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= 3'd0;
      active_q     <= 32'd0;
      shadow_q     <= 32'd0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign num        = active_q[{sel_q, 2'b00} +: 4];
  assign blank      = ~digit_en[sel_q];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with CLK_DIV = 4; k counts rising edges since reset release.
module tb_seven_seg_scanner;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        frame_done;

  int checks;
  int failures;
  int k;

  seven_seg_scanner #(.CLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
    .num        (num),
    .sel        (sel),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    value = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic load_now(input logic [31:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  function automatic logic [3:0] nib(input logic [31:0] v, input int s);
    return 4'((v >> (4 * s)) & 32'hF);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    k        = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 32'd0;
    digit_en = 8'hFF;

    // Reset state, then one full free-running frame with no load.
    do_reset();
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_num", 32'(num), 32'd0);
    check_eq("rst_blank", 32'(blank), 32'd0);
    check_eq("rst_fd", 32'(frame_done), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      check_eq("idle_sel", 32'(sel), 32'((k / DIV) % 8));
      check_eq("idle_num", 32'(num), 32'd0);
      check_eq("idle_blank", 32'(blank), 32'd0);
      check_eq("idle_fd", 32'(frame_done), (k == 32) ? 32'd1 : 32'd0);
    end

    // Load at cycle 2 of frame 0: invisible until the wrap, then F,E,..,8.
    do_reset();
    step();
    step();
    load_now(32'h89ABCDEF);
    while (k < 64) begin
      check_eq("load_num", 32'(num), (k < 32) ? 32'd0 : 32'(nib(32'h89ABCDEF, (k / DIV) % 8)));
      step();
    end

    // Load exactly on the wrap edge is bypassed into active.
    do_reset();
    while (k < 31) step();
    check_eq("byp_pre_sel", 32'(sel), 32'd7);
    check_eq("byp_pre_num", 32'(num), 32'd0);
    load_now(32'h12345678);
    check_eq("byp_sel", 32'(sel), 32'd0);
    check_eq("byp_num", 32'(num), 32'h8);
    check_eq("byp_pending", 32'(dut.pending_q), 32'd0);
    check_eq("byp_fd", 32'(frame_done), 32'd1);
    while (k < 64) begin
      step();
      check_eq("byp_frame_num", 32'(num), 32'(nib(32'h12345678, (k / DIV) % 8)));
    end

    // Two loads in one frame: only the last reaches the display.
    do_reset();
    while (k < 5) step();
    load_now(32'h11111111);
    while (k < 12) step();
    load_now(32'h22222222);
    while (k < 32) begin
      check_eq("two_pre_num", 32'(num), 32'd0);
      step();
    end
    while (k < 64) begin
      check_eq("two_num", 32'(num), 32'h2);
      step();
    end

    // Per-digit blanking: blank exactly at positions 1,3,4,6; num unaffected.
    digit_en = 8'b1010_0101;
    #1;
    for (int i = 0; i < 32; i++) begin
      check_eq("blank_flag", 32'(blank),
               (sel == 3'd1 || sel == 3'd3 || sel == 3'd4 || sel == 3'd6) ? 32'd1 : 32'd0);
      check_eq("blank_num", 32'(num), 32'h2);
      step();
    end
    digit_en = 8'hFF;

    // Mid-frame asynchronous reset with a pending load.
    do_reset();
    load_now(32'hFEDCBA98);
    while (k < 32) step();
    load_now(32'h77777777);
    while (k < 32 + 5 * DIV + 1) step();
    check_eq("mid_pre_sel", 32'(sel), 32'd5);
    check_eq("mid_pre_num", 32'(num), 32'hD);
    check_eq("mid_pre_pending", 32'(dut.pending_q), 32'd1);
    rst_n = 1'b0;
    #2;
    check_eq("async_sel", 32'(sel), 32'd0);
    check_eq("async_num", 32'(num), 32'd0);
    check_eq("async_blank", 32'(blank), 32'd0);
    check_eq("async_fd", 32'(frame_done), 32'd0);
    load  = 1'b1;
    value = 32'h55555555;
    @(posedge clk);
    #1;
    load = 1'b0;
    check_eq("rstload_num", 32'(num), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * 8 * DIV; i++) begin
      step();
      check_eq("post_rst_num", 32'(num), 32'd0);
      check_eq("post_rst_sel", 32'(sel), 32'((k / DIV) % 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout k=%0d got=running expected=finished", k);
    $fatal(1, "timeout");
  end

endmodule
